// File: rtl/csa_stream_pkg.sv
// csa_stream_pkg
// Shared defaults and types for the carry-save stream accumulator.
//   W      : operand width
//   ACC_W  : accumulator / result width (integer multiple of W)
//   CNT_W  : beat-count width
//   NCHUNK : number of W-bit chunks resolved after the last beat
//   state_t: accumulator control states
package csa_stream_pkg;

  localparam int W      = 4;
  localparam int ACC_W  = 12;
  localparam int CNT_W  = 8;
  localparam int NCHUNK = ACC_W / W;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/csa_chunk_adder.sv
// csa_chunk_adder
// W-bit ripple-carry adder built from fulladder cells; resolves one chunk
// of the redundant sum/carry pair per cycle.
//   a_i, b_i : W-bit addends
//   ci_i     : carry in from the previous chunk
//   sum_o    : W-bit sum
//   co_o     : carry out to the next chunk
module csa_chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);

  logic [W:0] carry;

  assign carry[0] = ci_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .c_i  (carry[i]),
      .s_o  (sum_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o = carry[W];

endmodule

// File: rtl/fulladder.sv
// fulladder
// Single-bit full-adder cell shared by the carry-save layer and the
// chunked carry-propagate adder.
//   a_i, b_i, c_i : addend bits
//   s_o           : sum bit  (a ^ b ^ c)
//   co_o          : carry    (majority of a, b, c)
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Accepts W-bit operand beats over valid/ready and accumulates them in
// carry-save form (one beat per cycle). After the last beat of a packet the
// redundant pair is resolved to binary one W-bit chunk per cycle, then the
// packet total and beat count are presented on a valid/ready output.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake
//   in_data, in_last      : operand beat and end-of-packet marker
//   out_valid/out_ready   : result handshake
//   out_data              : packet sum mod 2^ACC_W
//   out_count             : beats in packet, saturating
module csa_stream_accumulator #(
  parameter int W     = csa_stream_pkg::W,
  parameter int ACC_W = csa_stream_pkg::ACC_W,
  parameter int CNT_W = csa_stream_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  import csa_stream_pkg::*;

  localparam int NUM_CHUNK = ACC_W / W;
  localparam int CHUNK_W   = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNK - 1);

  state_t             state_q;
  logic [ACC_W-1:0]   s_q, c_q, res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic               carry_q;
  logic               in_ready_q, out_valid_q;

  // ---------------------------------------------------------------------
  // Carry-save layer: (s, c, d) -> (s_d, c_d) with s_d + c_d == s + c + d.
  // The carry out of the MSB is dropped, giving the mod 2^ACC_W wrap.
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] d_ext;
  logic [ACC_W-1:0] s_d, c_d;
  logic [ACC_W-1:0] csa_co;
  logic             unused_csa_msb;

  assign d_ext = ACC_W'(in_data);

  for (genvar i = 0; i < ACC_W; i++) begin : g_csa
    fulladder u_fa (
      .a_i  (s_q[i]),
      .b_i  (c_q[i]),
      .c_i  (d_ext[i]),
      .s_o  (s_d[i]),
      .co_o (csa_co[i])
    );
  end

  assign c_d            = {csa_co[ACC_W-2:0], 1'b0};
  assign unused_csa_msb = csa_co[ACC_W-1];

  // ---------------------------------------------------------------------
  // Chunked carry-propagate resolve
  // ---------------------------------------------------------------------
  logic [W-1:0]     chunk_s, chunk_c, chunk_sum;
  logic             chunk_co;
  logic [ACC_W-1:0] res_d;

  always_comb begin
    chunk_s = '0;
    chunk_c = '0;
    for (int k = 0; k < NUM_CHUNK; k++) begin
      if (chunk_q == CHUNK_W'(k)) begin
        chunk_s = s_q[k*W +: W];
        chunk_c = c_q[k*W +: W];
      end
    end
  end

  csa_chunk_adder #(.W(W)) u_chunk_adder (
    .a_i   (chunk_s),
    .b_i   (chunk_c),
    .ci_i  (carry_q),
    .sum_o (chunk_sum),
    .co_o  (chunk_co)
  );

  always_comb begin
    res_d = res_q;
    for (int k = 0; k < NUM_CHUNK; k++) begin
      if (chunk_q == CHUNK_W'(k)) begin
        res_d[k*W +: W] = chunk_sum;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      chunk_q     <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            s_q <= s_d;
            c_q <= c_d;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              state_q    <= RESOLVE;
              in_ready_q <= 1'b0;
              chunk_q    <= '0;
              carry_q    <= 1'b0;
            end
          end
        end

        RESOLVE: begin
          res_q   <= res_d;
          carry_q <= chunk_co;
          if (chunk_q == LAST_CHUNK) begin
            // Final carry-out is meaningless past ACC_W; it is simply not used.
            state_q     <= OUTPUT;
            out_valid_q <= 1'b1;
          end else begin
            chunk_q <= chunk_q + CHUNK_W'(1);
          end
        end

        OUTPUT: begin
          if (out_ready) begin
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
module tb_csa_stream_accumulator;

  localparam int W     = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int n_chk;
  int n_pass;

  csa_stream_accumulator #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat starting at a negedge; returns at the following negedge.
  task automatic beat(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for out_valid; returns number of negedges waited.
  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Expect a result with out_ready already high; checks the handshake returns to ACCUM.
  task automatic expect_result(input string tag, input int exp_data, input int exp_cnt);
    int lat;
    wait_out(tag, lat);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3 + 5 + 7 = 15
    beat(4'd3, 1'b0);
    beat(4'd5, 1'b0);
    beat(4'd7, 1'b1);
    expect_result("p357", 15, 3);

    // Single beat 9: out_valid exactly 3 cycles after acceptance
    beat(4'd9, 1'b1);
    chk("single_early_valid", 32'(out_valid), 32'd0);
    wait_out("single", lat);
    chk("single_latency", 32'(lat), 32'd3);
    expect_result("single", 9, 1);

    // 300 x 15 = 4500 -> 404, count saturates at 255
    for (int i = 0; i < 300; i++) begin
      chk("long_in_ready", 32'(in_ready), 32'd1);
      beat(4'd15, (i == 299));
    end
    expect_result("long", 404, 255);

    // Backpressure: 1 + 2 = 3, hold out_ready low 10 cycles with beat 6 offered
    out_ready = 1'b0;
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b1);
    wait_out("bp", lat);
    in_valid = 1'b1;
    in_data  = 4'd6;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'd3);
      chk("bp_count_held", 32'(out_count), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    beat(4'd4, 1'b1);
    expect_result("bp_next", 4, 1);

    // Reset mid-RESOLVE
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    idle(5);
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    beat(4'd1, 1'b1);
    expect_result("post_rst", 1, 1);

    // Gaps between beats: 2 + 4 + 8 = 14
    beat(4'd2, 1'b0);
    idle(2);
    beat(4'd4, 1'b0);
    idle(1);
    beat(4'd8, 1'b1);
    expect_result("gaps", 14, 3);

    // Wrap without saturation: 15*16 = 240 fits; 15 beats of 15 + beat 1 = 226
    for (int i = 0; i < 15; i++) beat(4'd15, 1'b0);
    beat(4'd1, 1'b1);
    expect_result("mix", 226, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
